bus_responder: RTL and testbench

Memory-side responder for the core's system bus: it accepts line-sized read and write requests issued by the cache and answers reads with an 8-beat data burst. It sits on the opposite end of the bus from the cache, backing a private word-addressed memory array, and serves as the simulation memory model for pipeline bring-up and as the template for the real memory controller.

---
 rtl/bus_pkg.sv | 21 ++
 rtl/resp_mem_array.sv | 26 ++
 rtl/bus_responder.sv | 161 ++++++++++++++++
 tb/tb_bus_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared system-bus definitions: tag field layout, line geometry and the
// memory responder's state encoding.
package bus_pkg;

    localparam int         TAG_DIR_BIT     = 12;
    localparam int         TAG_TYPE_MSB    = 11;
    localparam int         TAG_TYPE_LSB    = 8;
    localparam logic [3:0] TAG_TYPE_MEMORY = 4'b0001;
    localparam logic       TAG_DIR_READ    = 1'b1;
    localparam logic       TAG_DIR_WRITE   = 1'b0;

    localparam int LINE_BEATS = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WDATA,
        ST_RLAT,
        ST_RESP
    } resp_state_e;

endpackage

// File: rtl/resp_mem_array.sv
// Backing store for the bus responder: combinational read port and
// synchronous write port. Contents are never reset.
module resp_mem_array #(
    parameter  int WORDS = 4096,
    parameter  int DW    = 64,
    localparam int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/bus_responder.sv
// Memory-side bus responder: accepts line reads/writes from the cache and
// answers reads with a BEATS-long burst after a fixed latency.
module bus_responder
    import bus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_WORDS      = 4096,
    parameter int BEATS          = LINE_BEATS,
    parameter int READ_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      bus_respack
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int BW = $clog2(BEATS);
    localparam int LW = AW - 3;
    localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [CW-1:0] LAST_LAT  = CW'(READ_LATENCY - 1);

    resp_state_e               state_q, state_d;
    logic [BW-1:0]             beat_q, beat_d;
    logic [CW-1:0]             lat_q, lat_d;
    logic [LW-1:0]             line_q, line_d;
    logic                      is_mem_q, is_mem_d;
    logic                      reqack_q, reqack_d;
    logic                      respcyc_q, respcyc_d;
    logic [BUS_DATA_WIDTH-1:0] resp_q, resp_d;
    logic [BUS_TAG_WIDTH-1:0]  resptag_q, resptag_d;

    logic [AW-1:0]             base_w, rd_addr, wr_addr;
    logic [BW-1:0]             rd_beat;
    logic [BUS_DATA_WIDTH-1:0] rd_data;
    logic                      mem_we;

    // Line base = line index * BEATS; word index arithmetic wraps mod MEM_WORDS.
    assign base_w  = AW'({line_q, {BW{1'b0}}});
    assign rd_beat = (state_q == ST_RESP && bus_respack) ? beat_q + 1'b1 : beat_q;
    assign rd_addr = base_w + AW'(rd_beat);
    assign wr_addr = base_w + AW'(beat_q);

    resp_mem_array #(
        .WORDS (MEM_WORDS),
        .DW    (BUS_DATA_WIDTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (wr_addr),
        .wdata_i (bus_req),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        lat_d     = lat_q;
        line_d    = line_q;
        is_mem_d  = is_mem_q;
        reqack_d  = 1'b0;
        respcyc_d = respcyc_q;
        resp_d    = resp_q;
        resptag_d = resptag_q;
        mem_we    = 1'b0;

        // A beat presented during its own ack cycle is the requester still
        // holding the previous one, so it is never sampled then.
        unique case (state_q)
            ST_IDLE: begin
                if (bus_reqcyc && !reqack_q) begin
                    line_d   = bus_req[AW+2:6];
                    is_mem_d = (bus_reqtag[TAG_TYPE_MSB:TAG_TYPE_LSB] == TAG_TYPE_MEMORY);
                    reqack_d = 1'b1;
                    beat_d   = '0;
                    lat_d    = '0;
                    if (bus_reqtag[TAG_DIR_BIT] == TAG_DIR_READ) begin
                        state_d   = ST_RLAT;
                        resptag_d = bus_reqtag;
                    end else begin
                        state_d = ST_WDATA;
                    end
                end
            end
            ST_WDATA: begin
                if (bus_reqcyc && !reqack_q) begin
                    mem_we   = is_mem_q;
                    reqack_d = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            ST_RLAT: begin
                if (lat_q == LAST_LAT) begin
                    state_d   = ST_RESP;
                    respcyc_d = 1'b1;
                    resp_d    = is_mem_q ? rd_data : '0;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (bus_respack) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d   = ST_IDLE;
                        beat_d    = '0;
                        respcyc_d = 1'b0;
                        resp_d    = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                        resp_d = is_mem_q ? rd_data : '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            beat_q    <= '0;
            lat_q     <= '0;
            line_q    <= '0;
            is_mem_q  <= 1'b0;
            reqack_q  <= 1'b0;
            respcyc_q <= 1'b0;
            resp_q    <= '0;
            resptag_q <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            lat_q     <= lat_d;
            line_q    <= line_d;
            is_mem_q  <= is_mem_d;
            reqack_q  <= reqack_d;
            respcyc_q <= respcyc_d;
            resp_q    <= resp_d;
            resptag_q <= resptag_d;
        end
    end

    assign bus_reqack  = reqack_q;
    assign bus_respcyc = respcyc_q;
    assign bus_resp    = resp_q;
    assign bus_resptag = resptag_q;

endmodule

// File: tb/tb_bus_responder.sv
// Directed + randomized bench for bus_responder, checked against a word-array
// model of the memory and the bus timing rules.
module tb_bus_responder;

    localparam int DW = 64;
    localparam int TW = 13;
    localparam int MW = 4096;
    localparam int NB = 8;
    localparam int RL = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          bus_reqcyc = 1'b0;
    logic [DW-1:0] bus_req = '0;
    logic [TW-1:0] bus_reqtag = '0;
    logic          bus_reqack;
    logic          bus_respcyc;
    logic [DW-1:0] bus_resp;
    logic [TW-1:0] bus_resptag;
    logic          bus_respack = 1'b0;

    logic [DW-1:0] model_mem [MW];
    int checks = 0;
    int passed = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    bus_responder #(
        .BUS_DATA_WIDTH (DW),
        .BUS_TAG_WIDTH  (TW),
        .MEM_WORDS      (MW),
        .BEATS          (NB),
        .READ_LATENCY   (RL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .bus_respack (bus_respack)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic int word_of(input logic [63:0] addr, input int i);
        return int'(((addr >> 6) * NB + i) % MW);
    endfunction

    function automatic bit is_mem(input logic [TW-1:0] tag);
        return tag[11:8] == 4'b0001;
    endfunction

    function automatic logic [DW-1:0] exp_beat(input logic [63:0] addr, input logic [TW-1:0] tag, input int i);
        return is_mem(tag) ? model_mem[word_of(addr, i)] : 64'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hdr(input logic [63:0] addr, input logic [TW-1:0] tag);
        int n;
        n = 0;
        bus_reqcyc = 1'b1;
        bus_req    = addr;
        bus_reqtag = tag;
        do begin
            tick();
            n++;
        end while (!bus_reqack && n < 40);
        check("hdr_ack_latency", n, 1);
        bus_reqcyc = 1'b0;
    endtask

    task automatic resp_phase(input logic [63:0] addr, input logic [TW-1:0] tag, input int mode,
                              input bit inject, input logic [63:0] iaddr, input logic [TW-1:0] itag);
        int n, got, cyc;
        bit ack;
        n = 0; got = 0; cyc = 0;
        while (!bus_respcyc && n < 40) begin
            tick();
            n++;
        end
        check("read_latency", n, RL);
        while (got < NB && cyc < 200) begin
            ack = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            if (inject && got == 2 && !bus_reqcyc) begin
                bus_reqcyc = 1'b1;
                bus_req    = iaddr;
                bus_reqtag = itag;
            end
            bus_respack = ack;
            check("resp_valid", bus_respcyc, 1);
            check("resp_data", bus_resp, exp_beat(addr, tag, got));
            check("resp_tag", bus_resptag, tag);
            check("no_ack_in_resp", bus_reqack, 0);
            tick();
            cyc++;
            if (ack) got++;
        end
        bus_respack = 1'b0;
        check("beats_accepted", got, NB);
        check("resp_done", bus_respcyc, 0);
    endtask

    task automatic write_txn(input logic [63:0] addr, input logic [TW-1:0] tag,
                             input logic [NB-1:0][DW-1:0] data);
        int n;
        hdr(addr, tag);
        for (int i = 0; i < NB; i++) begin
            n = 0;
            bus_reqcyc = 1'b1;
            bus_req    = data[i];
            do begin
                tick();
                n++;
                check("wr_no_resp", bus_respcyc, 0);
            end while (!bus_reqack && n < 40);
            check("wr_ack_latency", n, 2);
        end
        bus_reqcyc = 1'b0;
        if (is_mem(tag))
            for (int i = 0; i < NB; i++) model_mem[word_of(addr, i)] = data[i];
        tick();
        check("wr_ack_single", bus_reqack, 0);
    endtask

    task automatic read_txn(input logic [63:0] addr, input logic [TW-1:0] tag, input int mode);
        hdr(addr, tag);
        resp_phase(addr, tag, mode, 1'b0, 64'd0, '0);
    endtask

    initial begin
        logic [NB-1:0][DW-1:0] wd;
        logic [63:0] a, b;
        logic [TW-1:0] t;
        int n;

        for (int i = 0; i < MW; i++) begin
            model_mem[i] = {$urandom, $urandom};
            dut.u_mem.mem[i] = model_mem[i];
        end
        for (int i = 0; i < NB; i++) begin
            model_mem[64 + i] = 64'h1000 + 64'(i);
            dut.u_mem.mem[64 + i] = 64'h1000 + 64'(i);
        end

        repeat (3) tick();
        check("rst_reqack", bus_reqack, 0);
        check("rst_respcyc", bus_respcyc, 0);
        check("rst_resp", bus_resp, 0);
        check("rst_resptag", bus_resptag, 0);
        reset = 1'b0;

        // Preloaded line, fixed tag, respack tied high.
        read_txn(64'h200, 13'h1105, 0);

        // Write a line, then read it back through an unaligned address.
        for (int i = 0; i < NB; i++) wd[i] = 64'hA0 + 64'(i);
        write_txn(64'h200, 13'h0107, wd);
        read_txn(64'h23F, 13'h1105, 0);
        check("wr_readback_beat0", model_mem[64], 64'hA0);

        // respack toggling 1,0,0,1,...
        a = 64'($urandom_range(0, 32767));
        read_txn(a, {5'b1_0001, 8'($urandom)}, 1);

        // Top line of memory, offset bits ignored, random respack.
        read_txn(64'(MW * 8 - 64 + 3), 13'h1122, 2);

        // Address bits above the array size are ignored.
        read_txn(64'h1_0000_0200 | 64'($urandom_range(0, 63)), 13'h1133, 0);

        // Non-memory type: writes discarded, reads return zero.
        a = 64'($urandom_range(0, 32767));
        for (int i = 0; i < NB; i++) wd[i] = {$urandom, $urandom};
        write_txn(a, {5'b0_0010, 8'h44}, wd);
        read_txn(a, 13'h1155, 2);
        read_txn(a, {5'b1_0011, 8'h66}, 0);

        // Header presented during a burst waits for the burst to finish.
        a = 64'h200;
        b = 64'($urandom_range(0, 32767));
        hdr(a, 13'h1177);
        resp_phase(a, 13'h1177, 1, 1'b1, b, 13'h1188);
        check("late_hdr_no_ack_yet", bus_reqack, 0);
        tick();
        check("late_hdr_ack", bus_reqack, 1);
        bus_reqcyc = 1'b0;
        resp_phase(b, 13'h1188, 0, 1'b0, 64'd0, '0);

        // Reset while beat 3 is on the bus.
        a = 64'($urandom_range(0, 32767));
        hdr(a, 13'h1199);
        n = 0;
        while (!bus_respcyc && n < 40) begin
            tick();
            n++;
        end
        check("rst_mid_latency", n, RL);
        bus_respack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("rst_mid_beat", bus_resp, exp_beat(a, 13'h1199, i));
            tick();
        end
        check("rst_mid_beat3", bus_resp, exp_beat(a, 13'h1199, 3));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus_respack = 1'b0;
        check("rst_mid_respcyc", bus_respcyc, 0);
        check("rst_mid_resp", bus_resp, 0);
        check("rst_mid_resptag", bus_resptag, 0);
        check("rst_mid_reqack", bus_reqack, 0);
        read_txn(a, 13'h11AA, 0);

        // Random memory write/read pairs.
        for (int k = 0; k < 3; k++) begin
            a = 64'($urandom_range(0, 32767));
            t = {5'b0_0001, 8'($urandom)};
            for (int i = 0; i < NB; i++) wd[i] = {$urandom, $urandom};
            write_txn(a, t, wd);
            read_txn(a | 64'($urandom_range(0, 63)), {5'b1_0001, 8'($urandom)}, 2);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
